// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: result codes
// compatible with the existing 2-bit comparator, and the FSM state encoding.
package cmp_pkg;

  typedef enum logic [1:0] {
    EQUAL   = 2'b00,
    LARGER  = 2'b01,
    SMALLER = 2'b10
  } cmp_result_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } cmp_state_t;

endpackage

// File: rtl/seq_comparator_digit.sv
// Combinational unsigned magnitude comparator; the sequential comparator
// instantiates it at WIDTH=DIGIT to judge one digit per cycle.
module seq_comparator_digit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       code
);

  always_comb begin
    code = EQUAL;
    if (a > b) begin
      code = LARGER;
    end else if (a < b) begin
      code = SMALLER;
    end
  end

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-first, DIGIT bits per
// cycle, and stops at the first differing digit. start/busy/done handshake.
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result
);

  localparam int N     = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (DIGIT >= 1 && (WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("seq_comparator: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
  end

  // state is kept as a named signal so checkers can bind to the FSM directly
  cmp_state_t       state, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_d;
  logic             done_d;
  logic [1:0]       result_d;
  logic [1:0]       digit_code;

  seq_comparator_digit #(
    .WIDTH(DIGIT)
  ) u_digit (
    .a    (a_q[WIDTH-1 -: DIGIT]),
    .b    (b_q[WIDTH-1 -: DIGIT]),
    .code (digit_code)
  );

  always_comb begin
    state_d  = state;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    case (state)
      IDLE: begin
        if (start) begin
          a_d = num_1;
          b_d = num_2;
          // offset-binary mapping: flipping the sign bits turns a signed
          // compare into an unsigned one for the rest of the scan
          if (signed_mode) begin
            a_d[WIDTH-1] = ~num_1[WIDTH-1];
            b_d[WIDTH-1] = ~num_2[WIDTH-1];
          end
          cnt_d   = CNT_W'(N - 1);
          busy_d  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (digit_code != EQUAL) begin
          result_d = digit_code;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (cnt == '0) begin
          result_d = EQUAL;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= EQUAL;
    end else begin
      state  <= state_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt    <= cnt_d;
      busy   <= busy_d;
      done   <= done_d;
      result <= result_d;
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator: 8-bit vector table, handshake and reset
// sequences, and an exhaustive 3-bit sweep at DIGIT=1 and DIGIT=3.
module tb_seq_comparator;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic       signed_mode;
  logic [7:0] num_1, num_2;
  logic       busy, done;
  logic [1:0] result;

  logic       s3_start;
  logic       s3_signed;
  logic [2:0] s3_a, s3_b;
  logic       d1_busy, d1_done, d3_busy, d3_done;
  logic [1:0] d1_result, d3_result;

  int errors = 0;
  int checks = 0;

  seq_comparator #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .num_1(num_1), .num_2(num_2), .busy(busy), .done(done), .result(result)
  );

  seq_comparator #(.WIDTH(3), .DIGIT(1)) u_w3d1 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .signed_mode(s3_signed),
    .num_1(s3_a), .num_2(s3_b), .busy(d1_busy), .done(d1_done), .result(d1_result)
  );

  seq_comparator #(.WIDTH(3), .DIGIT(3)) u_w3d3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .signed_mode(s3_signed),
    .num_1(s3_a), .num_2(s3_b), .busy(d3_busy), .done(d3_done), .result(d3_result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one 8-bit compare, returns result and cycles from start edge to done
  task automatic run_compare(input string name, input logic sm, input logic [7:0] a,
                             input logic [7:0] b, output logic [1:0] res, output int lat);
    signed_mode = sm;
    num_1       = a;
    num_2       = b;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    lat = 0;
    res = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_result_holds"}, 32'(result), 32'(res));
  endtask

  typedef struct {
    string      name;
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] exp_res;
    int         exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [1:0] res;
    int         lat;
    int         dones;
    int         first_done;
    logic [1:0] first_res;

    vecs[0]  = '{"u_a5_25",  1'b0, 8'hA5, 8'h25, 2'b01, 1};
    vecs[1]  = '{"u_3c_3c",  1'b0, 8'h3C, 8'h3C, 2'b00, 8};
    vecs[2]  = '{"u_10_11",  1'b0, 8'h10, 8'h11, 2'b10, 8};
    vecs[3]  = '{"s_ff_01",  1'b1, 8'hFF, 8'h01, 2'b10, 1};
    vecs[4]  = '{"u_ff_01",  1'b0, 8'hFF, 8'h01, 2'b01, 1};
    vecs[5]  = '{"s_80_7f",  1'b1, 8'h80, 8'h7F, 2'b10, 1};
    vecs[6]  = '{"u_00_ff",  1'b0, 8'h00, 8'hFF, 2'b10, 1};
    vecs[7]  = '{"s_fe_ff",  1'b1, 8'hFE, 8'hFF, 2'b10, 8};
    vecs[8]  = '{"u_7f_7e",  1'b0, 8'h7F, 8'h7E, 2'b01, 8};
    vecs[9]  = '{"s_01_00",  1'b1, 8'h01, 8'h00, 2'b01, 8};
    vecs[10] = '{"u_c0_c8",  1'b0, 8'hC0, 8'hC8, 2'b10, 5};

    rst_n = 1'b0;
    start = 1'b0; signed_mode = 1'b0; num_1 = '0; num_2 = '0;
    s3_start = 1'b0; s3_signed = 1'b0; s3_a = '0; s3_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_w3d1_busy", 32'(d1_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run_compare(vecs[i].name, vecs[i].sm, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, "_result"}, 32'(res), 32'(vecs[i].exp_res));
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    // start pulsed during an 8-cycle compare must be ignored
    signed_mode = 1'b0; num_1 = 8'h3C; num_2 = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; first_done = 0; first_res = 2'b11;
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) begin
        num_1 = 8'hA5; num_2 = 8'h25; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first_done == 0) begin
          first_done = c;
          first_res  = result;
        end
      end
    end
    start = 1'b0;
    check("busy_start_done_count", 32'(dones), 32'd1);
    check("busy_start_latency", 32'(first_done), 32'd8);
    check("busy_start_result", 32'(first_res), 32'(2'b00));

    // start on the done cycle is accepted back-to-back
    signed_mode = 1'b0; num_1 = 8'hA5; num_2 = 8'h25; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_result", 32'(result), 32'(2'b01));
    num_1 = 8'h10; num_2 = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_next", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    lat = 0; res = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
    check("b2b_second_latency", 32'(lat), 32'd8);
    check("b2b_second_result", 32'(res), 32'(2'b10));

    // reset in cycle 3 of a compare aborts it (result is SMALLER beforehand)
    num_1 = 8'h3C; num_2 = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_busy_idle", 32'(busy), 32'd0);

    // exhaustive 3-bit sweep against a behavioural model
    for (int sm = 0; sm < 2; sm++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          logic [2:0]        ua, ub, ma, mb, x;
          logic signed [2:0] sa, sb;
          logic [1:0]        exp_res, r1, r3;
          int                exp_lat1, l1, l3;
          ua = 3'(a); ub = 3'(b);
          sa = ua; sb = ub;
          if (sm == 1) begin
            exp_res = (sa == sb) ? 2'b00 : (sa > sb) ? 2'b01 : 2'b10;
          end else begin
            exp_res = (ua == ub) ? 2'b00 : (ua > ub) ? 2'b01 : 2'b10;
          end
          ma = ua; mb = ub;
          if (sm == 1) begin
            ma[2] = ~ua[2];
            mb[2] = ~ub[2];
          end
          x = ma ^ mb;
          exp_lat1 = x[2] ? 1 : x[1] ? 2 : 3;

          s3_signed = sm[0]; s3_a = ua; s3_b = ub; s3_start = 1'b1;
          @(posedge clk); #1;
          s3_start = 1'b0;
          l1 = 0; l3 = 0; r1 = 2'b11; r3 = 2'b11;
          for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (d1_done && l1 == 0) begin
              l1 = c; r1 = d1_result;
            end
            if (d3_done && l3 == 0) begin
              l3 = c; r3 = d3_result;
            end
            if (l1 != 0 && l3 != 0) break;
          end
          check($sformatf("w3d1_res_s%0d_%0d_%0d", sm, a, b), 32'(r1), 32'(exp_res));
          check($sformatf("w3d1_lat_s%0d_%0d_%0d", sm, a, b), 32'(l1), 32'(exp_lat1));
          check($sformatf("w3d3_res_s%0d_%0d_%0d", sm, a, b), 32'(r3), 32'(exp_res));
          check($sformatf("w3d3_lat_s%0d_%0d_%0d", sm, a, b), 32'(l3), 32'd1);
        end
      end
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit operands, signed or unsigned.
- Scans MSB-first, DIGIT bits per cycle, and stops early at the first differing digit.
- Serves as the ALU compare resource where a full-width single-cycle compare is too costly in area or timing.
- Handshake: start / busy / done. Result coding matches the existing 2-bit comparator codes.

Parameters:
- WIDTH, 8: operand width in bits. Must be >= 2.
- DIGIT, 1: bits examined per cycle. Must be >= 1 and divide WIDTH exactly.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare. Sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned. Sampled with start.
- num_1  input  WIDTH  first operand. Sampled with start.
- num_2  input  WIDTH  second operand. Sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  2  00 EQUAL, 01 LARGER (num_1 > num_2), 10 SMALLER (num_1 < num_2). 11 is never driven.

Behaviour:
- Reset values: busy=0, done=0, result=00, state=IDLE, internal digit counter and shift registers cleared.
- Reset mid-operation aborts the compare. No done pulse is issued and result returns to 00.
- States: IDLE and COMPARE.
- IDLE, start=1 at edge t0:
  - Latch operands into shift registers A and B.
  - If signed_mode=1, invert the MSB of both latched operands. This offset-binary mapping makes the remaining scan unsigned.
  - Load counter with N-1, where N=WIDTH/DIGIT.
  - busy<=1, state<=COMPARE.
- IDLE, start=0: nothing changes. result holds its last value.
- COMPARE, each edge: compare the top DIGIT bits of A and B as unsigned values.
  - Top digits differ: result<=LARGER or SMALLER, done<=1, busy<=0, state<=IDLE.
  - Digits equal and counter=0: result<=EQUAL, done<=1, busy<=0, state<=IDLE.
  - Digits equal and counter>0: shift A and B left by DIGIT, decrement counter, stay in COMPARE.
- Latency from the start edge t0 to done high:
  - Minimum 1 cycle (top digit differs), i.e. done high after edge t0+1.
  - Maximum N cycles (equal operands, or difference only in the last digit).
- done is high for exactly one cycle.
- result is stable from the done cycle until the next decision. Operand inputs may change freely while busy.
- start while busy=1 is ignored. No queuing.
- start in the same cycle as done (state already IDLE) is accepted: back-to-back compares are allowed.
- No arithmetic overflow is possible. The compare never subtracts; width growth is not needed.
- Illegal parameters (WIDTH<2, DIGIT<1, WIDTH%DIGIT!=0) cause an elaboration-time error through a generate check.

Decomposition:
- Shared package cmp_pkg:
  - Result codes EQUAL=2'b00, LARGER=2'b01, SMALLER=2'b10.
  - State encoding IDLE and COMPARE.
- One natural sub-module: the per-digit unsigned comparator (DIGIT-bit in, 2-bit code out, combinational). The team's existing parametrised comparator, instantiated with WIDTH=DIGIT, fills this role.
- The FSM, counter and shift registers stay in seq_comparator.

Test Plan:
1. WIDTH=8, DIGIT=1, unsigned, num_1=8'hA5, num_2=8'h25 -> result=01 (LARGER), done 1 cycle after the start edge, busy high 1 cycle.
2. Unsigned, num_1=num_2=8'h3C -> result=00 after 8 cycles. Then num_1=8'h10, num_2=8'h11 -> result=10 after 8 cycles.
3. Signed vs unsigned on the same operands:
   - signed_mode=1, 8'hFF vs 8'h01 -> 10 (-1<1). signed_mode=0, same operands -> 01.
   - signed_mode=1, 8'h80 vs 8'h7F -> 10 after 1 cycle.
4. Handshake:
   - Pulse start again at cycle 2 of an 8-cycle compare -> ignored, a single done.
   - Assert start on the done cycle -> a new compare begins, busy high the next cycle.
5. Reset mid-operation: drop rst_n at cycle 3 of a compare -> busy=0, done=0, result=00 immediately. No done after release until a new start.
6. Exhaustive check at WIDTH=3, DIGIT=1 and DIGIT=3:
   - All 64 operand pairs in both modes, checked against the behavioural model (num_1 == num_2 ? 00 : num_1 > num_2 ? 01 : 10), with $signed applied in signed mode.
   - Zero mismatches required. Latency must be <= WIDTH/DIGIT cycles.
